ring_osc_freq_counter: RTL and testbench
========================================

// Module: ring_osc_freq_counter
// PURPOSE
//  Digital measurement end of the on-chip ring oscillator. Drives the ring's enable, waits for it to
//  settle, then counts its rising edges over a window of clk cycles.
//  Latches the result, flags overflow, and exposes it bytewise for the 8-bit dedicated outputs.
//  The oscillator output arrives asynchronous to clk and is synchronised here. Only frequencies
//  below clk/2 measure correctly.
// PARAMETERS
//  COUNT_W        24   edge counter / result width, 1..32
//  GATE_BASE      256  base window length in clk cycles; window W = GATE_BASE << (2*gate_sel)
//  WARMUP_CYCLES  16   cycles osc_en is high before counting starts; 0 = count immediately
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  osc_in       in   1        raw ring oscillator output, async to clk
//  start        in   1        single-cycle request for one measurement
//  continuous   in   1        1 = re-arm back-to-back windows with no dead cycles
//  gate_sel     in   2        window select, sampled when leaving IDLE
//  byte_sel     in   2        result byte select for byte_out
//  osc_en       out  1        ring oscillator enable
//  busy         out  1        high in WARMUP or COUNT
//  count        out  COUNT_W  last completed measurement
//  overflow     out  1        last measurement saturated
//  count_valid  out  1        1-cycle pulse when count/overflow update
//  byte_out     out  8        count[8*byte_sel +: 8], zero-filled above COUNT_W; byte 3 = {7'b0,overflow}
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; all of the following are 0 immediately, with no clk edge
//  needed: osc_en, busy, count, overflow, count_valid, sync regs, edge/gate counters.
//  Synchroniser: osc_in -> s1 -> s2 -> s3. edge = s2 & ~s3. Edges are valid only in COUNT and
//  ignored elsewhere.
//  FSM states IDLE, WARMUP, COUNT. osc_en = busy = (state != IDLE), registered.
//  IDLE: exits when (start | continuous) is sampled high in cycle T.
//   - Latch gate_sel; load gate counter = W-1; clear edge counter and ovf.
//   - Next state is WARMUP, or COUNT when WARMUP_CYCLES = 0.
//  WARMUP: lasts exactly WARMUP_CYCLES cycles (T+1..T+WARMUP), then COUNT.
//  COUNT: lasts exactly W cycles.
//   - Each cycle with edge=1, edge counter +1.
//   - Counter saturates at 2^COUNT_W-1; an edge at saturation sets ovf.
//   - gate counter decrements each cycle.
//  Last COUNT cycle (gate counter == 0): on that clock edge:
//   - count <= final edge count, including an edge in the last cycle.
//   - overflow <= ovf; count_valid <= 1 for exactly one cycle.
//   - If continuous=1: stay in COUNT. Reload gate with the current latched W (gate_sel not
//     resampled). Clear edge counter/ovf. Skip WARMUP; osc_en stays high.
//   - Else: go to IDLE.
//  Latency: start sampled in cycle T -> count_valid high in cycle T+WARMUP_CYCLES+W+1.
//  Rule: start while busy is ignored, not queued.
//  Rule: gate_sel changes while busy are ignored.
//  Rule: continuous falling mid-window finishes the current window, then IDLE.
//  Rule: count/overflow hold their value until the next count_valid; never cleared except by reset.
//  Rule: byte_out is combinational from the count/overflow registers and byte_sel.
//  Gate counter width = clog2(GATE_BASE*64); it never wraps.
// TESTING
//  1. osc period 4 clk, gate_sel=0, start pulse at T
//     -> count=64, overflow=0, count_valid only at T+16+256+1.
//  2. Same osc, gate_sel=2 (W=4096) -> count=1024; byte_out: sel0=0x00, sel1=0x04, sel2=0x00, sel3=0x00.
//  3. COUNT_W=8, osc period 2 clk, gate_sel=2 -> count=255, overflow=1, byte_out sel3=0x01.
//  4. continuous=1, osc period 4, W=256 -> count_valid pulses spaced exactly 256 cycles,
//     each count=64, no WARMUP; drop continuous -> one more result, then busy=0.
//  5. start and gate_sel toggled mid-COUNT -> no restart, W unchanged, single count_valid.
//  6. rst_n low mid-COUNT -> osc_en, busy, count, count_valid = 0 immediately;
//     after release, start -> normal result.

Source files
------------

// File: rtl/ring_osc_freq_counter_if.sv
// Control/result bundle of the ring oscillator frequency counter.
// The measuring block sits on the slave side. The controller or bench sits on the master side.
interface ring_osc_freq_counter_if #(
    parameter int COUNT_W = 24
);
    logic               start;
    logic               continuous;
    logic [1:0]         gate_sel;
    logic [1:0]         byte_sel;
    logic               osc_en;
    logic               busy;
    logic [COUNT_W-1:0] count;
    logic               overflow;
    logic               count_valid;
    logic [7:0]         byte_out;

    modport master (
        output start, continuous, gate_sel, byte_sel,
        input  osc_en, busy, count, overflow, count_valid, byte_out
    );

    modport slave (
        input  start, continuous, gate_sel, byte_sel,
        output osc_en, busy, count, overflow, count_valid, byte_out
    );
endinterface

// File: rtl/ring_osc_freq_counter.sv
// Ring oscillator frequency counter. It enables the ring, waits for it to settle, and counts
// synchronised rising edges over a gate window of clk cycles. The result is exposed whole and bytewise.
module ring_osc_freq_counter #(
    parameter int COUNT_W       = 24,
    parameter int GATE_BASE     = 256,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_osc_in,
    ring_osc_freq_counter_if.slave bus
);
    localparam int GW = $clog2(GATE_BASE * 64);
    localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WW-1:0] WARM_LD = WW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WARMUP, COUNT} state_t;

    state_t             r_state, w_state_nx;
    logic               r_s1, r_s2, r_s3;
    logic [1:0]         r_gsel;
    logic [GW-1:0]      r_gate;
    logic [WW-1:0]      r_warm;
    logic [COUNT_W-1:0] r_edges, r_count, w_edges_nx;
    logic               r_ovf, r_overflow, r_valid, r_busy, w_ovf_nx;
    logic               w_edge, w_go, w_last, w_sat;
    logic [31:0]        w_ext;

    function automatic logic [GW-1:0] win_m1(input logic [1:0] sel);
        return GW'((GATE_BASE << (2 * sel)) - 1);
    endfunction

    assign w_go   = bus.start | bus.continuous;
    assign w_edge = r_s2 & ~r_s3 & (r_state == COUNT);
    assign w_last = (r_state == COUNT) && (r_gate == '0);
    assign w_sat  = &r_edges;
    // Saturating count. An edge arriving at full scale is recorded only as overflow.
    assign w_edges_nx = (w_edge && !w_sat) ? r_edges + COUNT_W'(1) : r_edges;
    assign w_ovf_nx   = r_ovf | (w_edge & w_sat);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_go) w_state_nx = (WARMUP_CYCLES == 0) ? COUNT : WARMUP;
            WARMUP:  if (r_warm == '0) w_state_nx = COUNT;
            COUNT:   if (r_gate == '0) w_state_nx = bus.continuous ? COUNT : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_gsel     <= '0;
            r_gate     <= '0;
            r_warm     <= '0;
            r_edges    <= '0;
            r_ovf      <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != IDLE);
            r_s1    <= i_osc_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_go) begin
                    r_gsel  <= bus.gate_sel;
                    r_gate  <= win_m1(bus.gate_sel);
                    r_warm  <= WARM_LD;
                    r_edges <= '0;
                    r_ovf   <= 1'b0;
                end
                WARMUP: r_warm <= r_warm - WW'(1);
                COUNT: if (w_last) begin
                    r_count    <= w_edges_nx;
                    r_overflow <= w_ovf_nx;
                    r_valid    <= 1'b1;
                    // Back-to-back windows reuse the window latched at the start of the run.
                    if (bus.continuous) begin
                        r_gate  <= win_m1(r_gsel);
                        r_edges <= '0;
                        r_ovf   <= 1'b0;
                    end
                end else begin
                    r_gate  <= r_gate - GW'(1);
                    r_edges <= w_edges_nx;
                    r_ovf   <= w_ovf_nx;
                end
                default: ;
            endcase
        end
    end

    assign w_ext = 32'(r_count);

    always_comb begin
        bus.byte_out = 8'h00;
        case (bus.byte_sel)
            2'd0: bus.byte_out = w_ext[7:0];
            2'd1: bus.byte_out = w_ext[15:8];
            2'd2: bus.byte_out = w_ext[23:16];
            default: bus.byte_out = {7'b0, r_overflow};
        endcase
    end

    assign bus.osc_en      = r_busy;
    assign bus.busy        = r_busy;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.count_valid = r_valid;
endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Scoreboard bench for ring_osc_freq_counter. It uses a 24-bit instance for timing and continuous runs,
// and an 8-bit instance for saturation.
module tb_ring_osc_freq_counter;
    localparam int WARM = 16;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    logic clk, rst_n, osc_a, osc_b;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [7:0] exb[4] = '{8'h00, 8'h04, 8'h00, 8'h00};

    ring_osc_freq_counter_if #(.COUNT_W(24)) bus_a ();
    ring_osc_freq_counter_if #(.COUNT_W(8))  bus_b ();

    ring_osc_freq_counter #(.COUNT_W(24), .GATE_BASE(256), .WARMUP_CYCLES(WARM)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_osc_in(osc_a), .bus(bus_a)
    );
    ring_osc_freq_counter #(.COUNT_W(8), .GATE_BASE(256), .WARMUP_CYCLES(WARM)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_osc_in(osc_b), .bus(bus_b)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    // Osc edges are offset from clk edges so the synchroniser never samples a transition.
    initial begin osc_a = 1'b0; #3; forever #20 osc_a = ~osc_a; end
    initial begin osc_b = 1'b0; #3; forever #10 osc_b = ~osc_b; end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_a.count_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("count", bus_a.count, e.cnt);
                chk("overflow", {31'b0, bus_a.overflow}, {31'b0, e.ovf});
            end
        end
    end

    task automatic start_a(input logic [1:0] gs, input int w, input int ncnt);
        @(negedge clk);
        bus_a.gate_sel = gs;
        bus_a.start    = 1'b1;
        sb.push_back('{cyc + 1 + WARM + w, ncnt, 1'b0});
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int k = 0;
        while (sb.size() > n && k < budget) begin @(negedge clk); k++; end
        if (sb.size() > n) chk(tag, sb.size(), n);
    endtask

    initial begin
        int base;
        int k;
        rst_n = 1'b0;
        bus_a.start = 0; bus_a.continuous = 0; bus_a.gate_sel = 0; bus_a.byte_sel = 0;
        bus_b.start = 0; bus_b.continuous = 0; bus_b.gate_sel = 0; bus_b.byte_sel = 0;
        #1;
        chk("rst_osc_en", {31'b0, bus_a.osc_en}, 0);
        chk("rst_busy", {31'b0, bus_a.busy}, 0);
        chk("rst_count", bus_a.count, 0);
        chk("rst_valid", {31'b0, bus_a.count_valid}, 0);
        chk("rst_overflow", {31'b0, bus_a.overflow}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single measurement, W=256, osc period 4 clk
        start_a(2'd0, 256, 64);
        repeat (40) @(negedge clk);
        chk("t1_osc_en_mid", {31'b0, bus_a.osc_en}, 1);
        wait_q(0, 400, "t1_timeout");
        @(negedge clk);
        chk("t1_busy_after", {31'b0, bus_a.busy}, 0);

        // W=4096, byte lanes of 1024
        start_a(2'd2, 4096, 1024);
        wait_q(0, 4300, "t2_timeout");
        for (int i = 0; i < 4; i++) begin
            bus_a.byte_sel = 2'(i);
            #1;
            chk($sformatf("t2_byte%0d", i), {24'b0, bus_a.byte_out}, {24'b0, exb[i]});
        end
        bus_a.byte_sel = 0;

        // 8-bit counter saturation with osc period 2 clk
        @(negedge clk);
        bus_b.gate_sel = 2'd2; bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        k = 0;
        while (!bus_b.count_valid && k < 4300) begin @(negedge clk); k++; end
        chk("t3_valid_seen", {31'b0, bus_b.count_valid}, 1);
        chk("t3_count", {24'b0, bus_b.count}, 32'd255);
        chk("t3_overflow", {31'b0, bus_b.overflow}, 1);
        bus_b.byte_sel = 2'd3;
        #1;
        chk("t3_byte3", {24'b0, bus_b.byte_out}, 32'h01);

        // Continuous windows back to back, then drop continuous
        @(negedge clk);
        bus_a.gate_sel = 2'd0; bus_a.continuous = 1'b1;
        base = cyc + 1 + WARM + 256;
        for (int i = 0; i < 4; i++) sb.push_back('{base + 256 * i, 64, 1'b0});
        wait_q(1, 1200, "t4_cont_timeout");
        @(negedge clk);
        bus_a.continuous = 1'b0;
        chk("t4_busy_last_window", {31'b0, bus_a.busy}, 1);
        wait_q(0, 400, "t4_last_timeout");
        @(negedge clk);
        chk("t4_busy_after", {31'b0, bus_a.busy}, 0);
        chk("t4_osc_en_after", {31'b0, bus_a.osc_en}, 0);

        // start and gate_sel wiggled mid-COUNT are ignored
        start_a(2'd0, 256, 64);
        repeat (100) @(negedge clk);
        chk("t5_busy_mid", {31'b0, bus_a.busy}, 1);
        bus_a.start = 1'b1; bus_a.gate_sel = 2'd3;
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_q(0, 400, "t5_timeout");
        @(negedge clk);
        chk("t5_no_restart", {31'b0, bus_a.busy}, 0);
        bus_a.gate_sel = 2'd0;

        // Asynchronous reset mid-COUNT
        start_a(2'd0, 256, 64);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_osc_en", {31'b0, bus_a.osc_en}, 0);
        chk("t6_busy", {31'b0, bus_a.busy}, 0);
        chk("t6_count", bus_a.count, 0);
        chk("t6_valid", {31'b0, bus_a.count_valid}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_a(2'd0, 256, 64);
        wait_q(0, 400, "t6_timeout");

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
